zeroriscy_multdiv_seq: RTL

- Iterative multiply/divide sequencer for the RV32M instructions.
- Owns no arithmetic of its own. It borrows the ALU's shared 33-bit adder through the multdiv operand/enable path, drives one addition per cycle, and keeps operand, partial-product, remainder and quotient state.
- Sits in EX beside the ALU. The core stalls EX while the sequencer is busy.

---
 rtl/zeroriscy_multdiv_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/zeroriscy_multdiv_seq.sv
// Iterative RV32M multiply/divide sequencer. It has no adder of its own: each cycle it drives
// the ALU's shared 33-bit adder and folds the sum into operand, product and remainder state.
module zeroriscy_multdiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [2:0]  operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  input  logic [33:0] adder_result_ext_i,
  output logic [32:0] multdiv_operand_a_o,
  output logic [32:0] multdiv_operand_b_o,
  output logic        multdiv_en_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  typedef enum logic [2:0] {
    StIdle, StAbsA, StAbsB, StPrep, StIter, StFixLo, StFixHi, StDone
  } state_e;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;

  state_e      state;
  logic [2:0]  op;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic        sa;
  logic        sb;
  logic [31:0] bmag;
  logic [32:0] negd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [4:0]  cnt;
  logic        carry;
  logic        en_reg;
  logic        valid_reg;
  logic [31:0] result_reg;

  logic [32:0] sum;
  logic        unused_sum_msb;
  logic        is_mul;
  logic        neg_lo;
  logic        neg_hi;
  logic        sel_hi;
  logic [31:0] hi_fixed;
  logic        start_sa;
  logic        start_sb;

  assign sum            = adder_result_ext_i[32:0];
  assign unused_sum_msb = adder_result_ext_i[33];

  assign is_mul   = ~op[2];
  assign neg_lo   = is_mul ? (sa ^ sb) : ((sa ^ sb) & (b_reg != 32'd0));
  assign neg_hi   = is_mul ? (sa ^ sb) : sa;
  assign sel_hi   = (op != OpMul) && (op != OpDiv) && (op != OpDivu);
  assign hi_fixed = neg_hi ? sum[31:0] : hi;

  assign start_sa = op_a_i[31] & ((operator_i == OpMulh) || (operator_i == OpMulhsu) ||
                                  (operator_i == OpDiv)  || (operator_i == OpRem));
  assign start_sb = op_b_i[31] & ((operator_i == OpMulh) || (operator_i == OpDiv) ||
                                  (operator_i == OpRem));

  always_comb begin
    multdiv_operand_a_o = 33'd0;
    multdiv_operand_b_o = 33'd0;
    case (state)
      StAbsA: begin
        multdiv_operand_a_o = {1'b0, ~a_reg};
        multdiv_operand_b_o = 33'd1;
      end
      StAbsB: begin
        multdiv_operand_a_o = {1'b0, ~b_reg};
        multdiv_operand_b_o = 33'd1;
      end
      StPrep: begin
        multdiv_operand_a_o = ~{1'b0, bmag};
        multdiv_operand_b_o = 33'd1;
      end
      StIter: begin
        if (is_mul) begin
          multdiv_operand_a_o = {1'b0, hi};
          multdiv_operand_b_o = lo[0] ? {1'b0, bmag} : 33'd0;
        end else begin
          // Trial subtraction of the divisor via its precomputed negation.
          multdiv_operand_a_o = {hi, lo[31]};
          multdiv_operand_b_o = negd;
        end
      end
      StFixLo: begin
        multdiv_operand_a_o = {1'b0, ~lo};
        multdiv_operand_b_o = 33'd1;
      end
      StFixHi: begin
        multdiv_operand_a_o = {1'b0, ~hi};
        multdiv_operand_b_o = is_mul ? {32'd0, carry} : 33'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      op         <= 3'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      sa         <= 1'b0;
      sb         <= 1'b0;
      bmag       <= 32'd0;
      negd       <= 33'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      cnt        <= 5'd0;
      carry      <= 1'b0;
      en_reg     <= 1'b0;
      valid_reg  <= 1'b0;
      result_reg <= 32'd0;
    end else if (kill_i && (state != StIdle)) begin
      state     <= StIdle;
      cnt       <= 5'd0;
      en_reg    <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state)
        StIdle: begin
          if (enable_i) begin
            op     <= operator_i;
            a_reg  <= op_a_i;
            b_reg  <= op_b_i;
            sa     <= start_sa;
            sb     <= start_sb;
            en_reg <= 1'b1;
            state  <= StAbsA;
          end
        end
        StAbsA: begin
          lo    <= sa ? sum[31:0] : a_reg;
          hi    <= 32'd0;
          state <= StAbsB;
        end
        StAbsB: begin
          bmag  <= sb ? sum[31:0] : b_reg;
          state <= StPrep;
        end
        StPrep: begin
          negd  <= sum;
          cnt   <= 5'd0;
          state <= StIter;
        end
        StIter: begin
          if (is_mul) begin
            hi <= sum[32:1];
            lo <= {sum[0], lo[31:1]};
          end else begin
            // No borrow out of bit 32 means the divisor fits: keep the difference.
            hi <= sum[32] ? {hi[30:0], lo[31]} : sum[31:0];
            lo <= {lo[30:0], ~sum[32]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            state <= StFixLo;
          end
        end
        StFixLo: begin
          if (neg_lo) begin
            lo <= sum[31:0];
          end
          carry <= sum[32];
          state <= StFixHi;
        end
        StFixHi: begin
          hi         <= hi_fixed;
          result_reg <= sel_hi ? hi_fixed : lo;
          en_reg     <= 1'b0;
          valid_reg  <= 1'b1;
          state      <= StDone;
        end
        StDone: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign multdiv_en_o = en_reg;
  assign valid_o      = valid_reg;
  assign result_o     = result_reg;

endmodule
